message_stream_splitter: RTL and testbench
==========================================

// Module: message_stream_splitter
// PURPOSE
//   Downstream stage of the message stream combiner. Consumes the single merged message stream
//   (data word + new-data strobe) and delimits it into packets. Recovers each packet's header,
//   tags the first and last payload words, and flags malformed traffic.
//   Sits between the combiner output and the message consumers (debug sink / host link).
// PARAMETERS
//   WIDTH                 32   data word width; bit WIDTH-1 of a header word is the header flag
//   MAX_PACKET_LENGTH     100  largest legal payload length in words; must be < 2**LOG_MAX_PACKET_LENGTH
//   LOG_MAX_PACKET_LENGTH 7    width of header length field (bits LOG_MAX_PACKET_LENGTH-1:0)
// PORTS
//   clk          in   1                      system clock, all logic on rising edge
//   rst_n        in   1                      asynchronous active-low reset
//   in_data      in   WIDTH                  merged stream word
//   in_nd        in   1                      in_data valid this cycle
//   out_data     out  WIDTH                  payload word
//   out_nd       out  1                      out_data valid (payload words only, never headers)
//   out_first    out  1                      with out_nd: first payload word of packet
//   out_last     out  1                      with out_nd: last payload word of packet
//   out_length   out  LOG_MAX_PACKET_LENGTH  length of current packet, held until next header
//   header_nd    out  1                      one-cycle pulse: valid header accepted
//   error        out  1                      one-cycle pulse: malformed input detected
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, count=0. out_data=0, out_nd=0, out_first=0,
//     out_last=0, out_length=0, header_nd=0, error=0. Reset mid-packet discards the packet;
//     the splitter resynchronises on the next header.
//   - All outputs registered. Latency: in_nd at edge N -> corresponding output at edge N+1.
//   - in_nd may be low on any cycle (gaps allowed); a cycle with in_nd=0 changes no state
//     and all pulse outputs are 0 that cycle.
//   - Header word: in_data[WIDTH-1]=1, L=in_data[LOG_MAX_PACKET_LENGTH-1:0].
//     Other header bits are ignored.
//   - IDLE, in_nd=1:
//       * header, 1<=L<=MAX: header_nd=1, out_length<=L, count<=L, -> PAYLOAD.
//       * header, L=0: header_nd=1, out_length<=0, stay IDLE (empty packet, no payload outputs).
//       * header, L>MAX: error=1, stay IDLE, out_length unchanged.
//       * non-header word: error=1, word dropped, stay IDLE.
//   - PAYLOAD, in_nd=1: every word is payload regardless of bit WIDTH-1.
//     out_data<=in_data, out_nd=1. out_first=1 iff count==out_length.
//     out_last=1 iff count==1. count<=count-1. When count reaches 0 -> IDLE.
//   - Single-word packet (L=1): out_first and out_last are both 1 on the same word.
//   - No backpressure: the splitter accepts a word every cycle; downstream must keep up.
//   - Count is unsigned LOG_MAX_PACKET_LENGTH bits; it never wraps because L<=MAX
//     is checked before load.
//   - error and header_nd never assert in the same cycle. out_nd is never asserted in IDLE.
// CONFIGURATION
//   MESSAGE_SPLITTER_STATS_EN defined:
//     - adds outputs packet_count[15:0] and error_count[15:0], reset 0.
//     - packet_count increments on each out_last or zero-length header_nd.
//     - error_count increments on each error pulse.
//     - Both counters saturate at 16'hFFFF.
//   MESSAGE_SPLITTER_STATS_EN undefined: these ports and counters are absent;
//     all other behaviour is identical.
// TESTING
//   1. Reset: hold rst_n=0 with in_nd toggling -> all outputs 0; release -> IDLE, no outputs.
//   2. Header 32'h8000_0003 then 32'h11, 32'h22, 32'h33 back-to-back
//      -> header_nd one cycle after the header, out_length=3.
//      -> out_data 11/22/33 with out_first on 11 and out_last on 33.
//   3. Header 32'h8000_0001, a 3-cycle in_nd=0 gap, then 32'h8000_00AA
//      -> one payload word 8000_00AA with out_first=out_last=1; no header_nd and no error for it.
//   4. 32'h0000_0005 in IDLE -> error=1, no out_nd.
//      Then header 32'h8000_0065 (L=101>100) -> error=1, out_length unchanged.
//   5. Header 32'h8000_0000 -> header_nd=1, out_length=0, no out_nd.
//      Next header 32'h8000_0002 is accepted normally.
//   6. rst_n pulsed low after 2 of 5 payload words -> outputs clear; next header 32'h8000_0002
//      plus 2 words -> correct packet.
//      With MESSAGE_SPLITTER_STATS_EN: packet_count=1, error_count=0.

Source files
------------

// File: rtl/message_stream_splitter.sv
// rtl/message_stream_splitter.sv - delimits the merged message stream into header-tagged payload packets
// Optional statistics counters are enabled with `define MESSAGE_SPLITTER_STATS_EN.
module message_stream_splitter #(
   parameter int WIDTH                 = 32,
   parameter int MAX_PACKET_LENGTH     = 100,
   parameter int LOG_MAX_PACKET_LENGTH = 7
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [WIDTH-1:0]                 in_data,
   input  logic                             in_nd,
   output logic [WIDTH-1:0]                 out_data,
   output logic                             out_nd,
   output logic                             out_first,
   output logic                             out_last,
   output logic [LOG_MAX_PACKET_LENGTH-1:0] out_length,
   output logic                             header_nd,
   output logic                             error
`ifdef MESSAGE_SPLITTER_STATS_EN
   ,
   output logic [15:0]                      packet_count,
   output logic [15:0]                      error_count
`endif
);

   localparam logic [LOG_MAX_PACKET_LENGTH-1:0] MAX_LEN = LOG_MAX_PACKET_LENGTH'(MAX_PACKET_LENGTH);
   localparam logic [LOG_MAX_PACKET_LENGTH-1:0] ONE     = LOG_MAX_PACKET_LENGTH'(1);

   typedef enum logic {
      IDLE    = 1'b0,
      PAYLOAD = 1'b1
   } state_t;

   state_t                           state;
   logic [LOG_MAX_PACKET_LENGTH-1:0] count;

   logic                             is_header;
   logic [LOG_MAX_PACKET_LENGTH-1:0] hdr_len;
   logic                             hdr_ok;

   // Only the flag bit and the length field of a header word carry meaning.
   assign is_header = in_data[WIDTH-1];
   assign hdr_len   = in_data[LOG_MAX_PACKET_LENGTH-1:0];
   assign hdr_ok    = is_header && (hdr_len <= MAX_LEN);

   // Packet delimiting FSM; pulse outputs default low and hold for exactly one accepted word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         out_data   <= '0;
         out_nd     <= 1'b0;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
         out_length <= '0;
         header_nd  <= 1'b0;
         error      <= 1'b0;
      end else begin
         out_nd    <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         header_nd <= 1'b0;
         error     <= 1'b0;
         if (in_nd) begin
            case (state)
               IDLE: begin
                  if (hdr_ok) begin
                     header_nd  <= 1'b1;
                     out_length <= hdr_len;
                     count      <= hdr_len;
                     // A zero-length header is a complete packet on its own.
                     if (hdr_len != '0) begin
                        state <= PAYLOAD;
                     end
                  end else begin
                     // Stray payload word or oversize header: drop it and wait for a header.
                     error <= 1'b1;
                  end
               end
               PAYLOAD: begin
                  // Inside a packet the header flag bit is ordinary payload data.
                  out_data  <= in_data;
                  out_nd    <= 1'b1;
                  out_first <= (count == out_length);
                  out_last  <= (count == ONE);
                  count     <= count - ONE;
                  if (count == ONE) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef MESSAGE_SPLITTER_STATS_EN
   logic pkt_evt;
   logic err_evt;

   // Completed packets: last payload word, or a zero-length header.
   assign pkt_evt = in_nd && (((state == PAYLOAD) && (count == ONE)) ||
                              ((state == IDLE) && hdr_ok && (hdr_len == '0)));
   assign err_evt = in_nd && (state == IDLE) && !hdr_ok;

   // Saturating statistics counters, updated alongside the pulses they count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         packet_count <= '0;
         error_count  <= '0;
      end else begin
         if (pkt_evt && (packet_count != 16'hFFFF)) begin
            packet_count <= packet_count + 16'd1;
         end
         if (err_evt && (error_count != 16'hFFFF)) begin
            error_count <= error_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_message_stream_splitter.sv
// tb/tb_message_stream_splitter.sv - scoreboard bench for message_stream_splitter
module tb_message_stream_splitter;

   localparam int W = 32;
   localparam int LW = 7;

   localparam logic [1:0] K_PAY = 2'd0;
   localparam logic [1:0] K_HDR = 2'd1;
   localparam logic [1:0] K_ERR = 2'd2;

   typedef struct packed {
      logic [1:0]    kind;
      logic [W-1:0]  data;
      logic          first;
      logic          last;
      logic [LW-1:0] len;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  in_data;
   logic          in_nd;
   logic [W-1:0]  out_data;
   logic          out_nd;
   logic          out_first;
   logic          out_last;
   logic [LW-1:0] out_length;
   logic          header_nd;
   logic          error;
`ifdef MESSAGE_SPLITTER_STATS_EN
   logic [15:0]   packet_count;
   logic [15:0]   error_count;
`endif

   exp_t exp_q[$];
   int   n_vec;
   int   n_bad;

   message_stream_splitter #(
      .WIDTH(W),
      .MAX_PACKET_LENGTH(100),
      .LOG_MAX_PACKET_LENGTH(LW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_nd(in_nd),
      .out_data(out_data),
      .out_nd(out_nd),
      .out_first(out_first),
      .out_last(out_last),
      .out_length(out_length),
      .header_nd(header_nd),
      .error(error)
`ifdef MESSAGE_SPLITTER_STATS_EN
      ,
      .packet_count(packet_count),
      .error_count(error_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every cycle with an output event pops the oldest expectation and compares.
   always @(negedge clk) begin
      exp_t e;
      if (out_nd || header_nd || error) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: nd=%b hdr=%b err=%b data=%h len=%0d with empty scoreboard",
                     out_nd, header_nd, error, out_data, out_length);
         end else begin
            e = exp_q.pop_front();
            if ((out_nd    !== (e.kind == K_PAY)) ||
                (header_nd !== (e.kind == K_HDR)) ||
                (error     !== (e.kind == K_ERR)) ||
                (out_length !== e.len) ||
                ((e.kind == K_PAY) && ((out_data !== e.data) || (out_first !== e.first) ||
                                       (out_last !== e.last)))) begin
               n_bad++;
               $display("FAIL event: got nd=%b hdr=%b err=%b data=%h first=%b last=%b len=%0d expected kind=%0d data=%h first=%b last=%b len=%0d",
                        out_nd, header_nd, error, out_data, out_first, out_last, out_length,
                        e.kind, e.data, e.first, e.last, e.len);
            end
         end
      end
   end

   task automatic drive(input logic [W-1:0] d);
      @(negedge clk);
      in_data = d;
      in_nd   = 1'b1;
   endtask

   task automatic send_hdr(input logic [W-1:0] d, input logic [LW-1:0] len);
      exp_t e;
      drive(d);
      e = '{kind: K_HDR, data: '0, first: 1'b0, last: 1'b0, len: len};
      exp_q.push_back(e);
   endtask

   task automatic send_pay(input logic [W-1:0] d, input logic f, input logic l, input logic [LW-1:0] len);
      exp_t e;
      drive(d);
      e = '{kind: K_PAY, data: d, first: f, last: l, len: len};
      exp_q.push_back(e);
   endtask

   task automatic send_err(input logic [W-1:0] d, input logic [LW-1:0] len);
      exp_t e;
      drive(d);
      e = '{kind: K_ERR, data: '0, first: 1'b0, last: 1'b0, len: len};
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_nd = 1'b0;
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {18'd0, out_data, out_nd, out_first, out_last, out_length, header_nd, error};
   endfunction

   // Hard stop if the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_vec   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      in_data = 32'h8000_0003;
      in_nd   = 1'b0;

      // 1. Reset held with in_nd toggling: outputs stay zero.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_nd = ~in_nd;
         chk("reset_outputs", all_outs(), 64'd0);
      end
      @(negedge clk);
      in_nd = 1'b0;
      rst_n = 1'b1;
      idle(2);
      chk("post_reset_outputs", all_outs(), 64'd0);

      // 2. Three-word packet back-to-back.
      send_hdr(32'h8000_0003, 7'd3);
      send_pay(32'h0000_0011, 1'b1, 1'b0, 7'd3);
      send_pay(32'h0000_0022, 1'b0, 1'b0, 7'd3);
      send_pay(32'h0000_0033, 1'b0, 1'b1, 7'd3);

      // 3. Single-word packet after a gap; payload carries the header flag bit.
      send_hdr(32'h8000_0001, 7'd1);
      idle(3);
      send_pay(32'h8000_00AA, 1'b1, 1'b1, 7'd1);

      // 4. Stray word in IDLE, then oversize header; length holds at 1.
      send_err(32'h0000_0005, 7'd1);
      send_err(32'h8000_0065, 7'd1);

      // 5. Empty packet, then a header with junk in the ignored bits (L = 0x82 & 0x7F = 2).
      send_hdr(32'h8000_0000, 7'd0);
      send_hdr(32'hC0F0_0082, 7'd2);
      send_pay(32'h0000_0044, 1'b1, 1'b0, 7'd2);
      send_pay(32'h0000_0055, 1'b0, 1'b1, 7'd2);

      // Largest legal packet (L = 100).
      send_hdr(32'h8000_0064, 7'd100);
      for (int i = 0; i < 100; i++) begin
         send_pay(32'h0001_0000 + i, (i == 0), (i == 99), 7'd100);
      end
      idle(2);

      // 6. Reset after 2 of 5 payload words, then a clean 2-word packet.
      send_hdr(32'h8000_0005, 7'd5);
      send_pay(32'h0000_00A1, 1'b1, 1'b0, 7'd5);
      send_pay(32'h0000_00A2, 1'b0, 1'b0, 7'd5);
      idle(2);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midpacket_reset_outputs", all_outs(), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      send_hdr(32'h8000_0002, 7'd2);
      send_pay(32'h0000_00B1, 1'b1, 1'b0, 7'd2);
      send_pay(32'h0000_00B2, 1'b0, 1'b1, 7'd2);
      idle(3);
`ifdef MESSAGE_SPLITTER_STATS_EN
      chk("packet_count", {48'd0, packet_count}, 64'd1);
      chk("error_count", {48'd0, error_count}, 64'd0);
`endif

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
